// File: rtl/punc_state_dumper.sv
// -----------------------------------------------------------------------------
// punc_state_dumper
//
// Observer for the PUnC processor's debug read ports. A start pulse makes it
// walk the PC, R0..R7 and a memory window of MEM_WORDS words starting at
// MEM_START. Each word goes out on a valid/ready stream with a source tag and
// an index.
//
// Optional feature, enabled with the macro PUNC_DUMP_CHECKSUM_EN:
//   a 16-bit running sum of every transferred word is kept. It is emitted as
//   one extra word (tag 3, index 0) after the last data word.
//
// Ports:
//   clk            clock
//   rst            asynchronous reset, active low
//   start          begin a dump; only looked at while idle
//   busy           high from the accepted start until done
//   done           one-cycle pulse after the last word transfers
//   rf_debug_addr  register index presented to PUnC
//   rf_debug_data  register data returned by PUnC
//   mem_debug_addr memory address presented to PUnC
//   mem_debug_data memory data returned by PUnC
//   pc_debug_data  current PC from PUnC
//   out_valid      stream word valid
//   out_ready      consumer ready
//   out_data       captured word
//   out_tag        source: 0=PC, 1=RF, 2=MEM, 3=checksum
//   out_index      register number, memory address, or 0
// -----------------------------------------------------------------------------
module punc_state_dumper #(
   parameter logic [15:0] MEM_START   = 16'h0000,
   parameter int unsigned MEM_WORDS   = 16,
   parameter int unsigned ADDR_SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [2:0]  rf_debug_addr,
   input  logic [15:0] rf_debug_data,
   output logic [15:0] mem_debug_addr,
   input  logic [15:0] mem_debug_data,
   input  logic [15:0] pc_debug_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic [1:0]  out_tag,
   output logic [15:0] out_index
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_VALID  = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   localparam logic [1:0] TAG_PC  = 2'd0;
   localparam logic [1:0] TAG_RF  = 2'd1;
   localparam logic [1:0] TAG_MEM = 2'd2;
   localparam logic [1:0] TAG_SUM = 2'd3;

   // Item numbering: 0 = PC, 1..8 = R0..R7, 9.. = memory words, then checksum.
   localparam logic [16:0] ITEM_PC        = 17'd0;
   localparam logic [16:0] FIRST_MEM_ITEM = 17'd9;
   localparam logic [16:0] MEM_END_ITEM   = 17'(32'd9 + MEM_WORDS);
`ifdef PUNC_DUMP_CHECKSUM_EN
   localparam logic [16:0] LAST_ITEM      = 17'(32'd9 + MEM_WORDS);
`else
   localparam logic [16:0] LAST_ITEM      = 17'(32'd8 + MEM_WORDS);
`endif
   localparam logic [3:0]  SETTLE_LOAD    = 4'(ADDR_SETTLE);

   logic [1:0]  state_r;
   logic [3:0]  settle_r;
   logic [16:0] item_r;

   logic [16:0] next_item_s;
   logic [2:0]  next_rf_addr_s;
   logic [15:0] next_mem_addr_s;
   logic [15:0] cap_data_s;
   logic [1:0]  cap_tag_s;
   logic [15:0] cap_index_s;

`ifdef PUNC_DUMP_CHECKSUM_EN
   logic [15:0] sum_r;
`endif

   // Pick the word, tag and index for the item whose address is on the bus.
   always_comb begin
      cap_data_s  = 16'h0000;
      cap_tag_s   = TAG_PC;
      cap_index_s = 16'h0000;
      if (item_r == ITEM_PC) begin
         cap_data_s = pc_debug_data;
      end else if (item_r < FIRST_MEM_ITEM) begin
         cap_data_s  = rf_debug_data;
         cap_tag_s   = TAG_RF;
         cap_index_s = {13'd0, rf_debug_addr};
      end else if (item_r < MEM_END_ITEM) begin
         cap_data_s  = mem_debug_data;
         cap_tag_s   = TAG_MEM;
         cap_index_s = mem_debug_addr;
      end else begin
`ifdef PUNC_DUMP_CHECKSUM_EN
         cap_data_s  = sum_r;
         cap_tag_s   = TAG_SUM;
`else
         cap_data_s  = 16'h0000;
         cap_tag_s   = TAG_PC;
`endif
         cap_index_s = 16'h0000;
      end
   end

   // Debug addresses for the following item. Register k is item k+1, and
   // memory word i is item i+9; the 16-bit add wraps past 16'hFFFF.
   always_comb begin
      next_item_s     = item_r + 17'd1;
      next_rf_addr_s  = rf_debug_addr;
      next_mem_addr_s = mem_debug_addr;
      if (next_item_s < FIRST_MEM_ITEM) begin
         next_rf_addr_s = item_r[2:0];
      end else if (next_item_s < MEM_END_ITEM) begin
         next_mem_addr_s = MEM_START + (item_r[15:0] - 16'd8);
      end else begin
         next_rf_addr_s  = rf_debug_addr;
         next_mem_addr_s = mem_debug_addr;
      end
   end

   // Dump sequencer: settle, present, wait for handshake, advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= ST_IDLE;
         settle_r       <= 4'd0;
         item_r         <= 17'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         out_valid      <= 1'b0;
         out_data       <= 16'h0000;
         out_tag        <= 2'd0;
         out_index      <= 16'h0000;
         rf_debug_addr  <= 3'd0;
         mem_debug_addr <= 16'h0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state_r       <= ST_SETTLE;
                  item_r        <= ITEM_PC;
                  settle_r      <= SETTLE_LOAD;
                  busy          <= 1'b1;
                  rf_debug_addr <= 3'd0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SETTLE: begin
               if (settle_r == 4'd0) begin
                  state_r   <= ST_VALID;
                  out_valid <= 1'b1;
                  out_data  <= cap_data_s;
                  out_tag   <= cap_tag_s;
                  out_index <= cap_index_s;
               end else begin
                  settle_r <= settle_r - 4'd1;
               end
            end
            ST_VALID: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (item_r == LAST_ITEM) begin
                     state_r <= ST_FINISH;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     state_r        <= ST_SETTLE;
                     item_r         <= next_item_s;
                     settle_r       <= SETTLE_LOAD;
                     rf_debug_addr  <= next_rf_addr_s;
                     mem_debug_addr <= next_mem_addr_s;
                  end
               end else begin
                  state_r <= ST_VALID;
               end
            end
            ST_FINISH: begin
               done    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r   <= ST_IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef PUNC_DUMP_CHECKSUM_EN
   // Running sum of transferred data words; the checksum word itself is excluded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_r <= 16'h0000;
      end else if ((state_r == ST_IDLE) && start) begin
         sum_r <= 16'h0000;
      end else if ((state_r == ST_VALID) && out_ready && (item_r != LAST_ITEM)) begin
         sum_r <= sum_r + out_data;
      end else begin
         sum_r <= sum_r;
      end
   end
`endif

endmodule

// File: tb/tb_punc_state_dumper.sv
// Bench for punc_state_dumper: three instances (basic window, wrapping
// window, empty window) share one scoreboard; one is selected per test.
module tb_punc_state_dumper;

   typedef struct packed {
      logic [1:0]  tag;
      logic [15:0] idx;
      logic [15:0] data;
   } exp_t;

   localparam logic [47:0] MS_TAB = {16'h0000, 16'hFFFE, 16'h3000};
   localparam logic [47:0] MW_TAB = {16'd0, 16'd4, 16'd4};

   logic clk;
   logic rst;
   logic out_ready;
   logic [15:0] pc_val;
   logic rf_flat;
   int   sel;

   logic        start_a [3];
   logic        busy_a  [3];
   logic        done_a  [3];
   logic        v_a     [3];
   logic [15:0] d_a     [3];
   logic [1:0]  tag_a   [3];
   logic [15:0] idx_a   [3];
   logic [2:0]  raddr_a [3];
   logic [15:0] rdata_a [3];
   logic [15:0] maddr_a [3];
   logic [15:0] mdata_a [3];

   logic        valid_s, busy_s, done_s;
   logic [15:0] data_s, idx_s, maddr_s;
   logic [1:0]  tag_s;
   logic [2:0]  raddr_s;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_total = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   last_xfer_cyc = 0;
   int   done_cnt = 0;

   // Stand-in for PUnC memory contents.
   function automatic logic [15:0] mem_model(input logic [15:0] a);
      if (a >= 16'h3000 && a <= 16'h3003) return 16'h000A + (a - 16'h3000);
      return a ^ 16'h5A5A;
   endfunction

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         assign rdata_a[g] = rf_flat ? 16'h0002 : (16'h1110 + {13'd0, raddr_a[g]});
         assign mdata_a[g] = mem_model(maddr_a[g]);
         punc_state_dumper #(
            .MEM_START  (MS_TAB[g*16 +: 16]),
            .MEM_WORDS  (int'(MW_TAB[g*16 +: 16])),
            .ADDR_SETTLE(1)
         ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .start         (start_a[g]),
            .busy          (busy_a[g]),
            .done          (done_a[g]),
            .rf_debug_addr (raddr_a[g]),
            .rf_debug_data (rdata_a[g]),
            .mem_debug_addr(maddr_a[g]),
            .mem_debug_data(mdata_a[g]),
            .pc_debug_data (pc_val),
            .out_valid     (v_a[g]),
            .out_ready     (out_ready),
            .out_data      (d_a[g]),
            .out_tag       (tag_a[g]),
            .out_index     (idx_a[g])
         );
      end
   endgenerate

   // Route the selected instance to the observed signals.
   always_comb begin
      case (sel)
         0: begin
            valid_s = v_a[0]; busy_s = busy_a[0]; done_s = done_a[0]; data_s = d_a[0];
            tag_s = tag_a[0]; idx_s = idx_a[0]; raddr_s = raddr_a[0]; maddr_s = maddr_a[0];
         end
         1: begin
            valid_s = v_a[1]; busy_s = busy_a[1]; done_s = done_a[1]; data_s = d_a[1];
            tag_s = tag_a[1]; idx_s = idx_a[1]; raddr_s = raddr_a[1]; maddr_s = maddr_a[1];
         end
         default: begin
            valid_s = v_a[2]; busy_s = busy_a[2]; done_s = done_a[2]; data_s = d_a[2];
            tag_s = tag_a[2]; idx_s = idx_a[2]; raddr_s = raddr_a[2]; maddr_s = maddr_a[2];
         end
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: every transfer pops one expected word.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         if (valid_s && out_ready) begin
            if (exp_q.size() == 0) begin
               check_val("extra_word", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check_val("tag",   32'(tag_s),  32'(mon_e.tag));
               check_val("index", 32'(idx_s),  32'(mon_e.idx));
               check_val("data",  32'(data_s), 32'(mon_e.data));
            end
            last_xfer_cyc = cyc;
         end
         if (done_s) begin
            done_cnt++;
            check_val("done_gap", 32'(cyc - last_xfer_cyc), 32'd1);
         end
      end
   end

   task automatic push_seq(input logic [15:0] ms, input int mw);
      exp_t e;
      logic [15:0] sum;
      logic [15:0] a;
      sum = 16'h0000;
      e = '{tag: 2'd0, idx: 16'h0000, data: pc_val};
      exp_q.push_back(e); sum = sum + e.data;
      for (int k = 0; k < 8; k++) begin
         e = '{tag: 2'd1, idx: 16'(k), data: rf_flat ? 16'h0002 : 16'h1110 + 16'(k)};
         exp_q.push_back(e); sum = sum + e.data;
      end
      for (int i = 0; i < mw; i++) begin
         a = ms + 16'(i);
         e = '{tag: 2'd2, idx: a, data: mem_model(a)};
         exp_q.push_back(e); sum = sum + e.data;
      end
`ifdef PUNC_DUMP_CHECKSUM_EN
      e = '{tag: 2'd3, idx: 16'h0000, data: sum};
      exp_q.push_back(e);
`endif
   endtask

   task automatic set_start(input int s, input logic v);
      for (int i = 0; i < 3; i++) start_a[i] = (i == s) ? v : 1'b0;
   endtask

   task automatic run_dump(input int s, input logic [15:0] ms, input int mw,
                           input bit bp, input bit abort_it, input bit dup);
      int  lat;
      int  bp_left;
      int  done0;
      bit  seen_valid;
      bit  aborted;
      sel = s;
      out_ready = 1'b1;
      push_seq(ms, mw);
      done0 = done_cnt;
      bp_left = bp ? 5 : 0;
      lat = 0;
      seen_valid = 1'b0;
      aborted = 1'b0;
      @(posedge clk); #1;
      set_start(s, 1'b1);
      @(posedge clk); #1;
      set_start(s, 1'b0);
      check_val("busy_up", 32'(busy_s), 32'd1);
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         set_start(s, (dup && c == 10) ? 1'b1 : 1'b0);
         if (done_cnt != done0) break;
         if (!seen_valid) begin
            lat++;
            if (valid_s) begin
               seen_valid = 1'b1;
               check_val("first_lat", 32'(lat), 32'd2);
            end
         end
         if (abort_it && valid_s && tag_s == 2'd2) begin
            rst = 1'b0;
            #1;
            check_val("abort_valid", 32'(valid_s), 32'd0);
            check_val("abort_busy",  32'(busy_s),  32'd0);
            aborted = 1'b1;
            break;
         end
         if (bp_left > 0 && valid_s && tag_s == 2'd1 && idx_s == 16'd3) begin
            out_ready = 1'b0;
            bp_left--;
            check_val("bp_data",  32'(data_s), 32'h1113);
            check_val("bp_index", 32'(idx_s),  32'd3);
         end else begin
            out_ready = 1'b1;
         end
      end
      set_start(s, 1'b0);
      out_ready = 1'b1;
      if (aborted) begin
         repeat (4) @(posedge clk);
         #1;
         check_val("abort_nodone", 32'(done_cnt), 32'(done0));
         rst = 1'b1;
         exp_q.delete();
      end else begin
         check_val("done_once",  32'(done_cnt), 32'(done0 + 1));
         check_val("q_empty",    32'(exp_q.size()), 32'd0);
         check_val("busy_down",  32'(busy_s), 32'd0);
         check_val("done_pulse", 32'(done_s), 32'd0);
         if (bp) check_val("bp_hold", 32'(bp_left), 32'd0);
         repeat (20) @(posedge clk);
         #1;
         check_val("idle_valid", 32'(valid_s), 32'd0);
         check_val("idle_done",  32'(done_cnt), 32'(done0 + 1));
         exp_q.delete();
      end
   endtask

   initial begin
      rst = 1'b0;
      out_ready = 1'b1;
      sel = 0;
      pc_val = 16'h3005;
      rf_flat = 1'b0;
      set_start(0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy",  32'(busy_s),  32'd0);
      check_val("rst_done",  32'(done_s),  32'd0);
      check_val("rst_valid", 32'(valid_s), 32'd0);
      check_val("rst_data",  32'(data_s),  32'd0);
      check_val("rst_tag",   32'(tag_s),   32'd0);
      check_val("rst_index", 32'(idx_s),   32'd0);
      check_val("rst_raddr", 32'(raddr_s), 32'd0);
      check_val("rst_maddr", 32'(maddr_s), 32'd0);
      rst = 1'b1;

      run_dump(0, 16'h3000, 4, 1'b0, 1'b0, 1'b0);   // basic
      run_dump(0, 16'h3000, 4, 1'b1, 1'b0, 1'b0);   // backpressure on R3
      run_dump(1, 16'hFFFE, 4, 1'b0, 1'b0, 1'b0);   // address wrap
      run_dump(2, 16'h0000, 0, 1'b0, 1'b0, 1'b0);   // empty window
      run_dump(0, 16'h3000, 4, 1'b0, 1'b1, 1'b0);   // abort in memory phase
      run_dump(0, 16'h3000, 4, 1'b0, 1'b0, 1'b1);   // restart, extra start while busy

      pc_val = 16'h0001;
      rf_flat = 1'b1;
      run_dump(2, 16'h0000, 0, 1'b0, 1'b0, 1'b0);   // checksum pattern

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
